// File: rtl/hamming_serial_rx.sv
// Serial receiver for Hamming(12,8) codewords: oversampled start/12-bit/stop framing,
// single-error correction and byte delivery on a valid/ready output.
module hamming_serial_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       arstn,
  input  logic       rx,
  output logic [7:0] q,
  output logic       q_valid,
  input  logic       q_ready,
  output logic       corrected,
  output logic       uncorrectable,
  output logic       frame_err,
  output logic       overflow
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_DECODE
  } state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_sync;
  logic          armed;
  logic [CW-1:0] cnt;
  logic [3:0]    bitcnt;
  logic [11:0]   hc;
  logic [3:0]    syn;
  logic          syn_bad;
  logic [7:0]    dec_data;

  // hc[i] holds codeword position i+1; syndrome bit k covers positions with index bit k set.
  always_comb begin
    syn[0]   = hc[0] ^ hc[2] ^ hc[4] ^ hc[6] ^ hc[8] ^ hc[10];
    syn[1]   = hc[1] ^ hc[2] ^ hc[5] ^ hc[6] ^ hc[9] ^ hc[10];
    syn[2]   = hc[3] ^ hc[4] ^ hc[5] ^ hc[6] ^ hc[11];
    syn[3]   = hc[7] ^ hc[8] ^ hc[9] ^ hc[10] ^ hc[11];
    syn_bad  = (syn >= 4'd13);
    dec_data = {hc[11] ^ (syn == 4'd12), hc[10] ^ (syn == 4'd11),
                hc[9]  ^ (syn == 4'd10), hc[8]  ^ (syn == 4'd9),
                hc[6]  ^ (syn == 4'd7),  hc[5]  ^ (syn == 4'd6),
                hc[4]  ^ (syn == 4'd5),  hc[2]  ^ (syn == 4'd3)};
  end

  // Output handshake: q/q_valid hold steady until a cycle with q_valid & q_ready;
  // q_valid then drops unless DECODE reloads a new byte in that same cycle.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state         <= S_IDLE;
      rx_meta       <= 1'b1;
      rx_sync       <= 1'b1;
      armed         <= 1'b0;
      cnt           <= '0;
      bitcnt        <= '0;
      hc            <= '0;
      q             <= '0;
      q_valid       <= 1'b0;
      corrected     <= 1'b0;
      uncorrectable <= 1'b0;
      frame_err     <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      rx_meta       <= rx;
      rx_sync       <= rx_meta;
      corrected     <= 1'b0;
      uncorrectable <= 1'b0;
      frame_err     <= 1'b0;
      overflow      <= 1'b0;
      if (q_valid && q_ready) q_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          // A line stuck low after a framing error must go high before a new start counts.
          if (rx_sync) begin
            armed <= 1'b1;
          end else if (armed) begin
            state  <= S_START;
            cnt    <= '0;
            bitcnt <= '0;
          end
        end
        S_START: begin
          if (cnt == HALF) begin
            cnt   <= '0;
            state <= rx_sync ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt == FULL) begin
            cnt        <= '0;
            hc[bitcnt] <= rx_sync;
            if (bitcnt == 4'd11) state <= S_STOP;
            else bitcnt <= bitcnt + 4'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (cnt == FULL) begin
            cnt <= '0;
            if (!rx_sync) begin
              frame_err <= 1'b1;
              armed     <= 1'b0;
              state     <= S_IDLE;
            end else begin
              state <= S_DECODE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DECODE: begin
          state <= S_IDLE;
          armed <= 1'b1;
          if (syn_bad) begin
            uncorrectable <= 1'b1;
          end else if (q_valid && !q_ready) begin
            overflow <= 1'b1;
          end else begin
            q         <= dec_data;
            q_valid   <= 1'b1;
            corrected <= (syn != 4'd0);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_serial_rx.sv
// Bench for hamming_serial_rx: directed and random frames, a reference model built on
// plain Hamming arithmetic, and a scoreboard monitor fed from expected-byte/event queues.
module tb_hamming_serial_rx;

  localparam int CPB = 16;
  localparam logic [2:0] EV_COR  = 3'd1;
  localparam logic [2:0] EV_UNC  = 3'd2;
  localparam logic [2:0] EV_FERR = 3'd3;
  localparam logic [2:0] EV_OVF  = 3'd4;

  logic       clk = 1'b0;
  logic       arstn;
  logic       rx;
  logic       q_ready;
  logic [7:0] q;
  logic       q_valid;
  logic       corrected;
  logic       uncorrectable;
  logic       frame_err;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [2:0] ev_q[$];
  int         dpos[8] = '{3, 5, 6, 7, 9, 10, 11, 12};

  logic       hold   = 1'b0;
  logic       prev_hs = 1'b0;
  logic [7:0] hold_q = 8'd0;

  // clock / reset
  always #5 clk = ~clk;

  hamming_serial_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .arstn        (arstn),
    .rx           (rx),
    .q            (q),
    .q_valid      (q_valid),
    .q_ready      (q_ready),
    .corrected    (corrected),
    .uncorrectable(uncorrectable),
    .frame_err    (frame_err),
    .overflow     (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // reference model
  function automatic logic [11:0] encode(input logic [7:0] d);
    logic [11:0] cw;
    logic        par;
    cw = '0;
    for (int i = 0; i < 8; i++) cw[dpos[i]-1] = d[i];
    for (int k = 0; k < 4; k++) begin
      par = 1'b0;
      for (int p = 1; p <= 12; p++)
        if (((p >> k) & 1) == 1 && p != (1 << k)) par = par ^ cw[p-1];
      cw[(1 << k) - 1] = par;
    end
    return cw;
  endfunction

  function automatic int syndrome(input logic [11:0] cw);
    int s;
    s = 0;
    for (int p = 1; p <= 12; p++) if (cw[p-1]) s = s ^ p;
    return s;
  endfunction

  task automatic predict(input logic [11:0] cw, input logic stop_ok, input logic rdy);
    int          s;
    logic [11:0] f;
    logic [7:0]  d;
    if (!stop_ok) begin
      ev_q.push_back(EV_FERR);
    end else begin
      s = syndrome(cw);
      if (s >= 13) begin
        ev_q.push_back(EV_UNC);
      end else if (!rdy && exp_q.size() != 0) begin
        ev_q.push_back(EV_OVF);
      end else begin
        f = cw;
        if (s != 0) f[s-1] = ~f[s-1];
        for (int i = 0; i < 8; i++) d[i] = f[dpos[i]-1];
        if (s != 0) ev_q.push_back(EV_COR);
        exp_q.push_back(d);
      end
    end
  endtask

  // driver
  task automatic send_frame(input logic [11:0] cw, input logic stop_bit, input logic rdy,
                            input int low_after);
    if (q_ready !== rdy) begin
      q_ready = rdy;
      tick(3);
    end
    predict(cw, stop_bit, rdy);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 12; i++) begin
      rx = cw[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
    if (!stop_bit) begin
      rx = 1'b0;
      tick(low_after);
      rx = 1'b1;
      tick(CPB);
    end
    rx = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_q"}, q, 0);
    check({tag, "_q_valid"}, q_valid, 0);
    check({tag, "_corrected"}, corrected, 0);
    check({tag, "_uncorrectable"}, uncorrectable, 0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_overflow"}, overflow, 0);
  endtask

  task automatic mon_pulse(input logic p, input logic [2:0] kind);
    if (p) begin
      if (ev_q.size() == 0) check($sformatf("spurious_pulse_%0d", kind), p, 0);
      else check("pulse_kind", kind, ev_q.pop_front());
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!arstn) begin
      hold    = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", q_valid, 1);
        check("hold_q", q, hold_q);
      end
      if (prev_hs) check("valid_drop", q_valid, 0);
      if (q_valid && q_ready) begin
        if (exp_q.size() == 0) check("spurious_q_valid", q_valid & q_ready, 0);
        else check("q_data", q, exp_q.pop_front());
      end
      mon_pulse(corrected, EV_COR);
      mon_pulse(uncorrectable, EV_UNC);
      mon_pulse(frame_err, EV_FERR);
      mon_pulse(overflow, EV_OVF);
      hold    = q_valid && !q_ready;
      prev_hs = q_valid && q_ready;
      hold_q  = q;
    end
  end

  // stimulus
  initial begin
    logic [7:0]  d;
    logic [11:0] cw;
    int          mode;
    int          a;
    int          b;
    logic        stop;
    logic        rdy;

    arstn   = 1'b0;
    rx      = 1'b1;
    q_ready = 1'b1;
    tick(3);
    check_zero("reset");
    arstn = 1'b1;
    tick(5);

    // clean frame, then every single-position error of the same codeword
    send_frame(12'hA27, 1'b1, 1'b1, 0);
    send_frame(12'hA07, 1'b1, 1'b1, 0);
    for (int p = 0; p < 12; p++) send_frame(12'hA27 ^ (12'd1 << p), 1'b1, 1'b1, 0);

    // double error landing on syndrome 13
    send_frame(12'hAB7, 1'b1, 1'b1, 0);

    // backpressure: second good frame overflows, then one handshake drains
    send_frame(12'hA27, 1'b1, 1'b0, 0);
    send_frame(encode(8'h3C), 1'b1, 1'b0, 0);
    q_ready = 1'b1;
    tick(3);
    check("bp_drained", q_valid, 0);

    // framing error, idle glitch, stuck-low line after error
    send_frame(12'hA27, 1'b0, 1'b1, 0);
    check("ferr_no_valid", q_valid, 0);
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(40);
    send_frame(12'hA27, 1'b0, 1'b1, 6 * CPB);
    send_frame(12'hA27, 1'b1, 1'b1, 0);

    // reset during data bit 6 while a byte is held
    send_frame(encode(8'h5A), 1'b1, 1'b0, 0);
    cw = encode(8'hC3);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 6; i++) begin
      rx = cw[i];
      tick(CPB);
    end
    rx = cw[6];
    tick(CPB / 2);
    arstn = 1'b0;
    #1;
    check_zero("mid_reset");
    exp_q.delete();
    rx = 1'b1;
    tick(4);
    arstn = 1'b1;
    tick(4);
    send_frame(12'hA27, 1'b1, 1'b1, 0);

    // random frames with mixed errors and backpressure
    repeat (40) begin
      d    = 8'($urandom);
      cw   = encode(d);
      mode = $urandom_range(0, 9);
      if (mode >= 4 && mode <= 6) begin
        a = $urandom_range(0, 11);
        cw[a] = ~cw[a];
      end else if (mode == 7) begin
        a = $urandom_range(0, 11);
        b = $urandom_range(0, 11);
        while (b == a) b = $urandom_range(0, 11);
        cw[a] = ~cw[a];
        cw[b] = ~cw[b];
      end
      stop = (mode != 8);
      rdy  = ($urandom_range(0, 3) != 0);
      send_frame(cw, stop, rdy, 0);
    end

    q_ready = 1'b1;
    for (int i = 0; i < 100 && (exp_q.size() != 0 || ev_q.size() != 0); i++) tick(1);
    check("exp_q_left", exp_q.size(), 0);
    check("ev_q_left", ev_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
